// File: rtl/chess_board_ram_if.sv
// Move-command handshake between game logic (master) and the board store (slave).
// The request is held by the master; completion is a one-cycle mv_done pulse.
interface chess_board_ram_if #(
    parameter int CODE_W = 6
);
    logic              mv_valid;
    logic              mv_ready;
    logic [5:0]        mv_from;
    logic [5:0]        mv_to;
    logic              mv_done;
    logic              mv_err;
    logic [CODE_W-1:0] mv_captured;

    modport master (
        output mv_valid,
        output mv_from,
        output mv_to,
        input  mv_ready,
        input  mv_done,
        input  mv_err,
        input  mv_captured
    );

    modport slave (
        input  mv_valid,
        input  mv_from,
        input  mv_to,
        output mv_ready,
        output mv_done,
        output mv_err,
        output mv_captured
    );
endinterface

// File: rtl/chess_board_ram.sv
// Writable 8x8 chess board: registered display read port, move sequencer that
// writes the destination then clears the source, and a start-position loader.
module chess_board_ram #(
    parameter int CODE_W = 6,
    parameter int N_SQ   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        char_xy,
    output logic [CODE_W-1:0] char_code,
    input  logic              new_game,
    output logic              init_busy,
    chess_board_ram_if.slave  mv
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_WR_DST,
        S_CLR_SRC,
        S_DONE
    } state_t;

    // White back rank; black pieces use the same order with codes offset by 6.
    localparam int BACK_RANK [8] = '{4, 3, 2, 5, 6, 2, 3, 4};

    logic [CODE_W-1:0] mem       [0:N_SQ-1];
    logic [CODE_W-1:0] start_tbl [0:N_SQ-1];

    state_t            state_q,      state_d;
    logic [5:0]        init_addr_q,  init_addr_d;
    logic [5:0]        from_q,       from_d;
    logic [5:0]        to_q,         to_d;
    logic [CODE_W-1:0] src_code_q,   src_code_d;
    logic [CODE_W-1:0] dst_code_q,   dst_code_d;
    logic              err_q,        err_d;
    logic [CODE_W-1:0] captured_q,   captured_d;
    logic [CODE_W-1:0] char_code_q,  char_code_d;

    logic              mem_we;
    logic [5:0]        mem_waddr;
    logic [CODE_W-1:0] mem_wdata;

    generate
        for (genvar gi = 0; gi < N_SQ; gi++) begin : g_start
            localparam int ROW  = gi / 8;
            localparam int COL  = gi % 8;
            localparam int CODE = (ROW == 7) ? BACK_RANK[COL] :
                                  (ROW == 0) ? BACK_RANK[COL] + 6 :
                                  (ROW == 6) ? 1 :
                                  (ROW == 1) ? 7 : 0;
            assign start_tbl[gi] = CODE_W'(CODE);
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        from_d      = from_q;
        to_d        = to_q;
        src_code_d  = src_code_q;
        dst_code_d  = dst_code_q;
        err_d       = err_q;
        captured_d  = captured_q;
        mem_we      = 1'b0;
        mem_waddr   = init_addr_q;
        mem_wdata   = '0;

        case (state_q)
            S_INIT: begin
                mem_we      = 1'b1;
                mem_waddr   = init_addr_q;
                mem_wdata   = start_tbl[init_addr_q];
                init_addr_d = init_addr_q + 6'd1;
                if (init_addr_q == 6'd63) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                // A new game wins over a simultaneous move request.
                if (new_game) begin
                    state_d     = S_INIT;
                    init_addr_d = '0;
                end else if (mv.mv_valid) begin
                    from_d  = mv.mv_from;
                    to_d    = mv.mv_to;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                src_code_d = mem[from_q];
                dst_code_d = mem[to_q];
                if ((from_q == to_q) || (mem[from_q] == '0)) begin
                    err_d      = 1'b1;
                    captured_d = '0;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_WR_DST;
                end
            end
            S_WR_DST: begin
                mem_we    = 1'b1;
                mem_waddr = to_q;
                mem_wdata = src_code_q;
                state_d   = S_CLR_SRC;
            end
            S_CLR_SRC: begin
                mem_we     = 1'b1;
                mem_waddr  = from_q;
                mem_wdata  = '0;
                err_d      = 1'b0;
                captured_d = dst_code_q;
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_INIT;
                init_addr_d = '0;
            end
        endcase
    end

    // Off-board addresses and the loading sweep both present an empty square.
    always_comb begin
        char_code_d = '0;
        if ((state_q != S_INIT) && !char_xy[7] && !char_xy[3]) begin
            char_code_d = mem[{char_xy[6:4], char_xy[2:0]}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_addr_q <= '0;
            from_q      <= '0;
            to_q        <= '0;
            src_code_q  <= '0;
            dst_code_q  <= '0;
            err_q       <= 1'b0;
            captured_q  <= '0;
            char_code_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            from_q      <= from_d;
            to_q        <= to_d;
            src_code_q  <= src_code_d;
            dst_code_q  <= dst_code_d;
            err_q       <= err_d;
            captured_q  <= captured_d;
            char_code_q <= char_code_d;
        end
    end

    // Board storage: the read port samples before this write lands (read-first).
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign char_code      = char_code_q;
    assign init_busy      = (state_q == S_INIT);
    assign mv.mv_ready    = (state_q == S_IDLE);
    assign mv.mv_done     = (state_q == S_DONE);
    assign mv.mv_err      = err_q;
    assign mv.mv_captured = captured_q;

endmodule
